// File: rtl/cs_compute_engine.sv
// cs_compute_engine: single-port RAM plus ALU executing RD/WR/ALU/MOV commands over a valid/ready handshake,
// with carry/zero status, optional saturation and out-of-range address detection.
module cs_compute_engine #(
  parameter int MEM_WIDTH = 8,
  parameter int MEM_DEPTH = 16,
  parameter bit SATURATE = 1'b0,
  localparam int ADDR_W = $clog2(MEM_DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [2:0]           op_sel,
  input  logic [ADDR_W-1:0]    addA,
  input  logic [ADDR_W-1:0]    addB,
  input  logic [ADDR_W-1:0]    addC,
  input  logic [MEM_WIDTH-1:0] dq_in,
  output logic [MEM_WIDTH-1:0] dq_out,
  output logic                 dq_oe,
  output logic                 done,
  output logic                 err,
  output logic                 carry,
  output logic                 zero
);
  localparam logic [2:0] OP_RD = 3'd0, OP_WR = 3'd1, OP_ADD = 3'd2, OP_SUB = 3'd3,
                         OP_AND = 3'd4, OP_OR = 3'd5, OP_MOV = 3'd7;
  localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(MEM_DEPTH);
  typedef enum logic [2:0] {IDLE, FETCH_A, FETCH_B, EXEC, WRITE} state_t;
  state_t state;
  logic [MEM_WIDTH-1:0] mem [MEM_DEPTH];
  logic [2:0] op;
  logic [ADDR_W-1:0] a, b, c;
  logic [MEM_WIDTH-1:0] wdata, opa, opb, raw, res;
  logic [MEM_WIDTH:0] sum, dif;
  logic bad, cmd_bad, oob_a, oob_b, oob_c, alu_c, we;
  assign cmd_ready = state == IDLE;
  assign oob_a = {1'b0, addA} >= DEPTH;
  assign oob_b = {1'b0, addB} >= DEPTH;
  assign oob_c = {1'b0, addC} >= DEPTH;
  assign cmd_bad = op_sel == OP_WR ? oob_c :
                   op_sel == OP_RD ? oob_a :
                   op_sel == OP_MOV ? (oob_a | oob_c) : (oob_a | oob_b | oob_c);
  assign sum = {1'b0, opa} + {1'b0, opb};
  assign dif = {1'b0, opa} - {1'b0, opb};
  assign alu_c = op == OP_ADD ? sum[MEM_WIDTH] : op == OP_SUB ? dif[MEM_WIDTH] : 1'b0;
  assign raw = op == OP_ADD ? sum[MEM_WIDTH-1:0] :
               op == OP_SUB ? dif[MEM_WIDTH-1:0] :
               op == OP_AND ? (opa & opb) :
               op == OP_OR  ? (opa | opb) : (opa ^ opb);
  // saturation: ADD overflow pins to all-ones, SUB borrow pins to zero
  assign res = (SATURATE && alu_c) ? {MEM_WIDTH{op == OP_ADD}} : raw;
  assign we = state == WRITE && !bad && !rst;
  always_ff @(posedge clk) begin
    if (we) mem[c] <= wdata;
  end
  always_ff @(posedge clk) begin
    done  <= 1'b0;
    dq_oe <= 1'b0;
    err   <= 1'b0;
    if (rst) begin
      state  <= IDLE;
      dq_out <= '0;
      carry  <= 1'b0;
      zero   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (cmd_valid) begin
          op    <= op_sel;
          a     <= addA;
          b     <= addB;
          c     <= addC;
          wdata <= dq_in;
          bad   <= cmd_bad;
          state <= (op_sel == OP_WR || cmd_bad) ? WRITE : FETCH_A;
        end
        FETCH_A: begin
          opa <= mem[a];
          if (op == OP_RD) begin
            dq_out <= mem[a];
            dq_oe  <= 1'b1;
            done   <= 1'b1;
            state  <= IDLE;
          end else if (op == OP_MOV) begin
            wdata <= mem[a];
            state <= WRITE;
          end else begin
            state <= FETCH_B;
          end
        end
        FETCH_B: begin
          opb   <= mem[b];
          state <= EXEC;
        end
        EXEC: begin
          wdata <= res;
          carry <= alu_c;
          zero  <= res == '0;
          state <= WRITE;
        end
        WRITE: begin
          done  <= 1'b1;
          err   <= bad;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cs_compute_engine.sv
// tb_cs_compute_engine: directed scoreboard bench over three engine instances
// (wrap/16 words, saturating/16 words, wrap/12 words).
module tb_cs_compute_engine;
  localparam logic [2:0] RD = 3'd0, WR = 3'd1, ADD = 3'd2, SUB = 3'd3,
                         AND_ = 3'd4, OR_ = 3'd5, XOR_ = 3'd6, MOV = 3'd7;
  logic clk_tb = 1'b0;
  logic rst;
  logic [2:0] cmd_valid, cmd_ready, dq_oe, done, err, carry, zero;
  logic [2:0][2:0] op_sel;
  logic [2:0][3:0] addA, addB, addC;
  logic [2:0][7:0] dq_in, dq_out;
  int checks = 0;
  int failures = 0;
  typedef struct {
    string tag;
    int lat;
    logic er, oe;
    logic [7:0] dq;
    logic c, z;
  } exp_t;
  exp_t q[$];
  always #5 clk_tb = ~clk_tb;
  for (genvar i = 0; i < 3; i++) begin : g
    cs_compute_engine #(.MEM_WIDTH(8), .MEM_DEPTH(i == 2 ? 12 : 16), .SATURATE(i == 1)) dut (
      .clk(clk_tb), .rst(rst), .cmd_valid(cmd_valid[i]), .cmd_ready(cmd_ready[i]),
      .op_sel(op_sel[i]), .addA(addA[i]), .addB(addB[i]), .addC(addC[i]), .dq_in(dq_in[i]),
      .dq_out(dq_out[i]), .dq_oe(dq_oe[i]), .done(done[i]), .err(err[i]),
      .carry(carry[i]), .zero(zero[i]));
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic cmd(input string tag, input int n, input logic [2:0] op, input logic [3:0] a, b, c,
                     input logic [7:0] d, input int lat, input logic er, oe, input logic [7:0] dq,
                     input logic ec, ez);
    exp_t e;
    int k = 0;
    q.push_back('{tag, lat, er, oe, dq, ec, ez});
    @(negedge clk_tb);
    chk({tag, ".ready"}, 32'(cmd_ready[n]), 1);
    cmd_valid[n] = 1'b1; op_sel[n] = op; addA[n] = a; addB[n] = b; addC[n] = c; dq_in[n] = d;
    @(posedge clk_tb);
    #1 cmd_valid[n] = 1'b0;
    do begin
      @(posedge clk_tb);
      #1 k++;
    end while (!done[n] && k < 12);
    e = q.pop_front();
    chk({e.tag, ".lat"}, k, e.lat);
    chk({e.tag, ".err"}, 32'(err[n]), 32'(e.er));
    chk({e.tag, ".oe"}, 32'(dq_oe[n]), 32'(e.oe));
    if (e.oe) chk({e.tag, ".dq"}, 32'(dq_out[n]), 32'(e.dq));
    chk({e.tag, ".carry"}, 32'(carry[n]), 32'(e.c));
    chk({e.tag, ".zero"}, 32'(zero[n]), 32'(e.z));
  endtask
  initial begin
    int pulses;
    rst = 1'b1; cmd_valid = '0; op_sel = '0; addA = '0; addB = '0; addC = '0; dq_in = '0;
    repeat (2) @(posedge clk_tb);
    #1 rst = 1'b0;
    for (int n = 0; n < 3; n++) begin
      chk("rst.ready", 32'(cmd_ready[n]), 1);
      chk("rst.done", 32'(done[n]), 0);
      chk("rst.oe", 32'(dq_oe[n]), 0);
      chk("rst.err", 32'(err[n]), 0);
      chk("rst.dq", 32'(dq_out[n]), 0);
      chk("rst.flags", {30'd0, carry[n], zero[n]}, 0);
    end
    // instance 0: wrap-around, 16 words
    cmd("wr8",   0, WR, 0, 0, 8,  8'h3C, 1, 0, 0, 0, 0, 0);
    cmd("wr10",  0, WR, 0, 0, 10, 8'hF0, 1, 0, 0, 0, 0, 0);
    cmd("wr5",   0, WR, 0, 0, 5,  8'h20, 1, 0, 0, 0, 0, 0);
    cmd("wr12",  0, WR, 0, 0, 12, 8'h05, 1, 0, 0, 0, 0, 0);
    cmd("wr3",   0, WR, 0, 0, 3,  8'h05, 1, 0, 0, 0, 0, 0);
    cmd("rd8",   0, RD, 8, 0, 0,  8'h00, 1, 0, 1, 8'h3C, 0, 0);
    cmd("wr1",   0, WR, 0, 0, 1,  8'hFF, 1, 0, 0, 0, 0, 0);
    cmd("rd1",   0, RD, 1, 0, 0,  8'h00, 1, 0, 1, 8'hFF, 0, 0);
    cmd("add",   0, ADD, 10, 5, 13, 8'h00, 4, 0, 0, 0, 1, 0);
    cmd("rd13",  0, RD, 13, 0, 0, 8'h00, 1, 0, 1, 8'h10, 1, 0);
    cmd("sub0",  0, SUB, 12, 3, 7, 8'h00, 4, 0, 0, 0, 0, 1);
    cmd("rd7",   0, RD, 7, 0, 0,  8'h00, 1, 0, 1, 8'h00, 0, 1);
    cmd("xor",   0, XOR_, 7, 7, 7, 8'h00, 4, 0, 0, 0, 0, 1);
    cmd("rd7x",  0, RD, 7, 0, 0,  8'h00, 1, 0, 1, 8'h00, 0, 1);
    cmd("dbl",   0, ADD, 8, 8, 8, 8'h00, 4, 0, 0, 0, 0, 0);
    cmd("rd8d",  0, RD, 8, 0, 0,  8'h00, 1, 0, 1, 8'h78, 0, 0);
    cmd("subb",  0, SUB, 5, 10, 6, 8'h00, 4, 0, 0, 0, 1, 0);
    cmd("rd6",   0, RD, 6, 0, 0,  8'h00, 1, 0, 1, 8'h30, 1, 0);
    cmd("and",   0, AND_, 10, 8, 9, 8'h00, 4, 0, 0, 0, 0, 0);
    cmd("rd9",   0, RD, 9, 0, 0,  8'h00, 1, 0, 1, 8'h70, 0, 0);
    cmd("or",    0, OR_, 5, 12, 11, 8'h00, 4, 0, 0, 0, 0, 0);
    cmd("rd11",  0, RD, 11, 0, 0, 8'h00, 1, 0, 1, 8'h25, 0, 0);
    cmd("mov",   0, MOV, 8, 0, 0, 8'h00, 2, 0, 0, 0, 0, 0);
    cmd("rd0",   0, RD, 0, 0, 0,  8'h00, 1, 0, 1, 8'h78, 0, 0);
    // instance 1: saturating
    cmd("s.wr10", 1, WR, 0, 0, 10, 8'hF0, 1, 0, 0, 0, 0, 0);
    cmd("s.wr5",  1, WR, 0, 0, 5,  8'h20, 1, 0, 0, 0, 0, 0);
    cmd("s.add",  1, ADD, 10, 5, 13, 8'h00, 4, 0, 0, 0, 1, 0);
    cmd("s.rd13", 1, RD, 13, 0, 0, 8'h00, 1, 0, 1, 8'hFF, 1, 0);
    cmd("s.sub",  1, SUB, 5, 10, 6, 8'h00, 4, 0, 0, 0, 1, 1);
    cmd("s.rd6",  1, RD, 6, 0, 0,  8'h00, 1, 0, 1, 8'h00, 1, 1);
    // instance 2: 12 words, out-of-range addresses
    cmd("d.wr1",  2, WR, 0, 0, 1, 8'hF0, 1, 0, 0, 0, 0, 0);
    cmd("d.wr2",  2, WR, 0, 0, 2, 8'h5A, 1, 0, 0, 0, 0, 0);
    cmd("d.wr4",  2, WR, 0, 0, 4, 8'h11, 1, 0, 0, 0, 0, 0);
    cmd("d.add",  2, ADD, 1, 1, 3, 8'h00, 4, 0, 0, 0, 1, 0);
    cmd("d.eadd", 2, ADD, 1, 1, 13, 8'h00, 1, 1, 0, 0, 1, 0);
    cmd("d.erd",  2, RD, 14, 0, 0, 8'h00, 1, 1, 0, 0, 1, 0);
    cmd("d.ewr",  2, WR, 0, 0, 12, 8'h99, 1, 1, 0, 0, 1, 0);
    cmd("d.esub", 2, SUB, 1, 12, 3, 8'h00, 1, 1, 0, 0, 1, 0);
    cmd("d.rd3",  2, RD, 3, 0, 0, 8'h00, 1, 0, 1, 8'hE0, 1, 0);
    cmd("d.rd1",  2, RD, 1, 0, 0, 8'h00, 1, 0, 1, 8'hF0, 1, 0);
    cmd("d.mov",  2, MOV, 2, 0, 4, 8'h00, 2, 0, 0, 0, 1, 0);
    cmd("d.rd4",  2, RD, 4, 0, 0, 8'h00, 1, 0, 1, 8'h5A, 1, 0);
    // back-to-back RD then WR with cmd_valid held high
    @(negedge clk_tb);
    cmd_valid[0] = 1'b1; op_sel[0] = RD; addA[0] = 4'd8;
    @(posedge clk_tb);
    #1 chk("b2b.busy", 32'(cmd_ready[0]), 0);
    op_sel[0] = WR; addC[0] = 4'd14; dq_in[0] = 8'h77;
    @(posedge clk_tb);
    #1 chk("b2b.rd_done", {done[0], dq_oe[0], cmd_ready[0]}, 3'b111);
    chk("b2b.rd_dq", 32'(dq_out[0]), 32'h78);
    @(posedge clk_tb);
    #1 cmd_valid[0] = 1'b0;
    chk("b2b.accepted", {done[0], cmd_ready[0]}, 2'b00);
    @(posedge clk_tb);
    #1 chk("b2b.wr_done", {done[0], err[0]}, 2'b10);
    cmd("b2b.rd14", 0, RD, 14, 0, 0, 8'h00, 1, 0, 1, 8'h77, 0, 0);
    // reset while the ADD sits in EXEC: no write, no done
    @(negedge clk_tb);
    cmd_valid[0] = 1'b1; op_sel[0] = ADD; addA[0] = 4'd10; addB[0] = 4'd10; addC[0] = 4'd13;
    @(posedge clk_tb);
    #1 cmd_valid[0] = 1'b0;
    repeat (2) @(posedge clk_tb);
    #1 rst = 1'b1;
    @(posedge clk_tb);
    #1 rst = 1'b0;
    chk("rstx.ready", 32'(cmd_ready[0]), 1);
    chk("rstx.done", 32'(done[0]), 0);
    pulses = 0;
    repeat (6) begin
      @(posedge clk_tb);
      #1 pulses += int'(done[0]);
    end
    chk("rstx.no_done", pulses, 0);
    cmd("rstx.rd13", 0, RD, 13, 0, 0, 8'h00, 1, 0, 1, 8'h10, 0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
